// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the memory port arbiter
package mem_arb_pkg;
  localparam int WORD_W = 64;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - grant picker with memory-stage priority and fetch anti-starvation run counter
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DM_RUN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  output logic if_gnt_o,
  output logic dm_gnt_o
);
  localparam int RW = $clog2(MAX_DM_RUN + 1);

  logic [RW-1:0] run_q, run_d;
  logic          run_full;

  assign run_full = (run_q == RW'(MAX_DM_RUN));

  // Fetch only overtakes the memory stage once it has waited out a full run.
  always_comb begin
    if_gnt_o = idle_i && if_req_i && (!dm_req_i || run_full);
    dm_gnt_o = idle_i && dm_req_i && !(if_req_i && run_full);
  end

  always_comb begin
    run_d = run_q;
    if (if_gnt_o) begin
      run_d = '0;
    end else if (dm_gnt_o && if_req_i) begin
      if (!run_full) run_d = run_q + 1'b1;
    end else if (idle_i && !if_req_i) begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= '0;
    else        run_q <= run_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter for fetch and memory stage
// Optional wait-cycle counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned MAX_DM_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AW-1:0]     dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [WORD_W-1:0] ram_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_wait_cnt,
  output logic [31:0]       dm_wait_cnt
`endif
);
  logic [1:0]        state_q, state_d;
  logic              owner_q, we_q;
  logic [AW-1:0]     addr_q;
  logic [WORD_W-1:0] wdata_q, rdata_q;
  logic              if_rvalid_q, dm_rvalid_q, err_q;
  logic              grant, done, in_range;
  logic [AW-1:0]     gnt_addr;

  // Gating with rst_n keeps the combinational grants low while reset is held.
  mem_arb_prio #(.MAX_DM_RUN(MAX_DM_RUN)) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle_i   (rst_n && (state_q == IDLE)),
    .if_req_i (if_req),
    .dm_req_i (dm_req),
    .if_gnt_o (if_gnt),
    .dm_gnt_o (dm_gnt)
  );

  assign grant    = if_gnt || dm_gnt;
  assign gnt_addr = dm_gnt ? dm_addr : if_addr;
  assign in_range = (32'(gnt_addr) < DEPTH);
  assign done     = ((state_q == BUSY) && ram_ack) || (state_q == ERR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = in_range ? BUSY : ERR;
      BUSY:    if (ram_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      if (grant) begin
        owner_q <= dm_gnt ? OWN_DM : OWN_IF;
        we_q    <= dm_gnt && dm_we;
        addr_q  <= gnt_addr;
        wdata_q <= dm_gnt ? dm_wdata : '0;
      end
      // Writes and address errors complete with zero data.
      if (done) begin
        if_rvalid_q <= (owner_q == OWN_IF);
        dm_rvalid_q <= (owner_q == OWN_DM);
        err_q       <= (state_q == ERR);
        rdata_q     <= ((state_q == BUSY) && !we_q) ? ram_rdata : '0;
      end
    end
  end

  assign ram_req   = (state_q == BUSY);
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rvalid_q ? rdata_q : '0;
  assign dm_rdata  = dm_rvalid_q ? rdata_q : '0;
  assign if_err    = if_rvalid_q && err_q;
  assign dm_err    = dm_rvalid_q && err_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] if_wait_q, dm_wait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_wait_q <= '0;
      dm_wait_q <= '0;
    end else begin
      if (if_req && !if_gnt) if_wait_q <= if_wait_q + 32'd1;
      if (dm_req && !dm_gnt) dm_wait_q <= dm_wait_q + 32'd1;
    end
  end

  assign if_wait_cnt = if_wait_q;
  assign dm_wait_cnt = dm_wait_q;
`endif
endmodule
